// File: rtl/carry_chain_pipe.sv
// -----------------------------------------------------------------------------
// carry_chain_pipe
//
// Purpose:
//   Pipelined propagate/generate carry chain. The WIDTH-bit chain is cut into
//   STAGES = WIDTH/SEG segments with a register stage after each segment.
//   P/G of later segments and the sums of earlier segments ride along the
//   pipeline, so all bits of one vector leave together and one result per
//   cycle is sustained. Valid/ready handshake on both sides; a single global
//   advance enable (en = !out_valid || out_ready) moves or freezes the whole
//   pipeline.
//
//   Per bit:  C[0] = Ci,  C[i+1] = P[i] ? C[i] : G[i],  S[i] = P[i] ^ C[i]
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   P/G/Ci hold a vector
//   in_ready   out  vector accepted this cycle (forced high during rst)
//   P, G       in   WIDTH-bit propagate / generate
//   Ci         in   chain carry-in
//   out_valid  out  S/Co hold a result
//   out_ready  in   downstream consumes the result this cycle
//   S          out  WIDTH-bit sum
//   Co         out  carry out of bit WIDTH-1
//   V          out  two's-complement overflow C[WIDTH]^C[WIDTH-1]
//                   (only with CARRY_CHAIN_PIPE_OVERFLOW_EN)
//
// Configuration macro:
//   CARRY_CHAIN_PIPE_OVERFLOW_EN - adds the registered overflow output V.
// -----------------------------------------------------------------------------
module carry_chain_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
    output logic             Co,
    output logic             V
`else
    output logic             Co
`endif
);

    // Derived; guarded so a bad SEG still reaches the elaboration error below.
    localparam int STAGES = (SEG < 1) ? 1 : (WIDTH / SEG);

    generate
        if (SEG < 1) begin : g_bad_seg
            $error("carry_chain_pipe: SEG must be >= 1");
        end else if ((WIDTH % SEG) != 0) begin : g_bad_width
            $error("carry_chain_pipe: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Pipeline state: r_p/r_g[k] feed stage k+1, r_s/r_c[k] are stage k outputs.
    logic [WIDTH-1:0] r_p   [STAGES];
    logic [WIDTH-1:0] r_g   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_vld [STAGES];

    // Combinational stage results.
    logic [WIDTH-1:0] w_s [STAGES];
    logic             w_c [STAGES];
    logic [WIDTH-1:0] w_cur_p;
    logic [WIDTH-1:0] w_cur_g;
    logic [WIDTH-1:0] w_cur_s;
    logic             w_carry;
    logic             w_en;

`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
    logic             w_v;
    logic             r_v;
`endif

    // Global advance: the pipeline moves unless a result is stalled at the output.
    always_comb begin
        w_en     = (!r_vld[STAGES-1]) || out_ready;
        in_ready = w_en || rst;
    end

    // Segment evaluation: each stage ripples SEG bits from its skewed P/G slice.
    always_comb begin
        w_cur_p = {WIDTH{1'b0}};
        w_cur_g = {WIDTH{1'b0}};
        w_cur_s = {WIDTH{1'b0}};
        w_carry = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                w_cur_p = P;
                w_cur_g = G;
                w_cur_s = {WIDTH{1'b0}};
                w_carry = Ci;
            end else begin
                w_cur_p = r_p[k-1];
                w_cur_g = r_g[k-1];
                w_cur_s = r_s[k-1];
                w_carry = r_c[k-1];
            end
            for (int b = 0; b < SEG; b++) begin
                w_cur_s[k*SEG+b] = w_cur_p[k*SEG+b] ^ w_carry;
                w_carry          = w_cur_p[k*SEG+b] ? w_carry : w_cur_g[k*SEG+b];
            end
            w_s[k] = w_cur_s;
            w_c[k] = w_carry;
        end
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
        // C[WIDTH-1] is recovered as S[WIDTH-1]^P[WIDTH-1] from the last stage.
        w_v = w_carry ^ w_cur_s[WIDTH-1] ^ w_cur_p[WIDTH-1];
`endif
    end

    // Pipeline registers: reset clears everything, otherwise shift when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_p[k]   <= {WIDTH{1'b0}};
                r_g[k]   <= {WIDTH{1'b0}};
                r_s[k]   <= {WIDTH{1'b0}};
                r_c[k]   <= 1'b0;
                r_vld[k] <= 1'b0;
            end
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
            r_v <= 1'b0;
`endif
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_s[k] <= w_s[k];
                r_c[k] <= w_c[k];
                if (k == 0) begin
                    r_p[k]   <= P;
                    r_g[k]   <= G;
                    r_vld[k] <= in_valid;
                end else begin
                    r_p[k]   <= r_p[k-1];
                    r_g[k]   <= r_g[k-1];
                    r_vld[k] <= r_vld[k-1];
                end
            end
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
            r_v <= w_v;
`endif
        end
    end

    // Outputs come straight from the last stage registers.
    assign S         = r_s[STAGES-1];
    assign Co        = r_c[STAGES-1];
    assign out_valid = r_vld[STAGES-1];
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
    assign V         = r_v;
`endif

endmodule

// File: tb/tb_carry_chain_pipe.sv
// -----------------------------------------------------------------------------
// tb_carry_chain_pipe
//
// Scoreboard bench for carry_chain_pipe (WIDTH=16, SEG=4). The driver pushes
// the hand-computed result of every accepted vector into a queue; a monitor
// pops and compares whenever the DUT hands a result downstream. Inputs change
// on the falling edge, observations happen shortly after it.
// -----------------------------------------------------------------------------
module tb_carry_chain_pipe;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] G;
    logic             Ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
    logic             V;
`endif

    int checks = 0;
    int errors = 0;

    // expected {S, Co, V}
    logic [17:0] exp_q [$];

    carry_chain_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .G         (G),
        .Ci        (Ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
        .Co        (Co),
        .V         (V)
`else
        .Co        (Co)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one add vector (a + b + ci) and hold it until accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] es, input logic eco, input logic ev);
        int  tries;
        bit  done;
        logic rdy;
        tries = 0;
        done  = 1'b0;
        @(negedge clk);
        P        = a ^ b;
        G        = a & b;
        Ci       = ci;
        in_valid = 1'b1;
        while (!done) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back({es, eco, ev});
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: vector a=0x%0h not accepted after %0d cycles", a, tries);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        logic [17:0] e;
        logic        act_v;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: S=0x%0h Co=%0b with empty scoreboard", S, Co);
            end else begin
                e = exp_q.pop_front();
`ifdef CARRY_CHAIN_PIPE_OVERFLOW_EN
                act_v = V;
`else
                act_v = e[0];
`endif
                chk("result_S_Co_V", {14'd0, S, Co, act_v}, {14'd0, e});
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        P         = 16'h0000;
        G         = 16'h0000;
        Ci        = 1'b0;

        // Reset state
        @(negedge clk);
        #1 chk("in_ready_in_reset", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_Co", Co, 0);
        chk("rst_in_ready", in_ready, 1);

        // Propagate-through, with exact latency and single-cycle out_valid
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("latency_out_valid", out_valid, (i == 3) ? 1 : 0);
        end
        drain();

        // Single adds
        send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        idle(1);
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();

        // Streaming: 8 back-to-back, in_ready must stay high
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        #1 chk("stream_in_ready", in_ready, 1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        #1 chk("stream_in_ready", in_ready, 1);
        send(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);
        send(16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        #1 chk("stream_in_ready", in_ready, 1);
        send(16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
        #1 chk("stream_in_ready", in_ready, 1);
        drain();

        // Backpressure: fill the pipe with out_ready low, hold two cycles
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'h0100, 16'h0200, 1'b1, 16'h0301, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_S", S, 16'h0007);
            chk("stall_Co", Co, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset mid-stream with two vectors in flight
        send(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0);
        send(16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1 chk("in_ready_rst_mid", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_S", S, 0);
        chk("midrst_Co", Co, 0);
        idle(6);

        // Overflow vectors and a stream after reset
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
